cfu_arbiter2: RTL and testbench

- Shares one CFU (popcount, BNN dot product, MulAcc or MulAccSIMD class) between two requesters, e.g. two harts or a hart plus a test sequencer.
- Round-robin arbitration of CFU requests.
- Records the grant order in a tag FIFO and steers each CFU response back to the requester that issued it.
- Sits between the requesters' CFU request/response ports and a single CFU that returns responses in order.

---
 rtl/cfu_arbiter2.sv | 175 +++++++++++++++++
 tb/tb_cfu_arbiter2.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_arbiter2.sv
// Two-requester round-robin front end for a single in-order CFU.
// Optional per-requester grant/stall counters with CFU_ARB_PERF_EN.
module cfu_arbiter2 #(
    parameter int CFU_FUNCTION_ID_W = 1,
    parameter int CFU_REQ_INPUTS    = 2,
    parameter int CFU_REQ_DATA_W    = 32,
    parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
    parameter int DEPTH             = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     req0_valid,
    output logic                                     req0_ready,
    input  logic [CFU_FUNCTION_ID_W-1:0]             req0_func,
    input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0] req0_data,
    output logic                                     resp0_valid,
    input  logic                                     resp0_ready,
    output logic [CFU_RESP_DATA_W-1:0]               resp0_data,
    input  logic                                     req1_valid,
    output logic                                     req1_ready,
    input  logic [CFU_FUNCTION_ID_W-1:0]             req1_func,
    input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0] req1_data,
    output logic                                     resp1_valid,
    input  logic                                     resp1_ready,
    output logic [CFU_RESP_DATA_W-1:0]               resp1_data,
    output logic                                     cfu_req_valid,
    input  logic                                     cfu_req_ready,
    output logic [CFU_FUNCTION_ID_W-1:0]             cfu_req_func,
    output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0] cfu_req_data,
    input  logic                                     cfu_resp_valid,
    output logic                                     cfu_resp_ready,
    input  logic [CFU_RESP_DATA_W-1:0]               cfu_resp_data,
    output logic                                     err_orphan
`ifdef CFU_ARB_PERF_EN
    ,
    output logic [15:0]                              perf_grant0,
    output logic [15:0]                              perf_grant1,
    output logic [15:0]                              perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] tags_q, tags_d;
    logic             ptr_q, ptr_d;
    logic             err_q, err_d;

    logic run;
    logic full;
    logic empty;
    logic any_req;
    logic sel;
    logic push;
    logic pop;
    logic orphan;
    logic head;
    logic head_valid;
    logic head_ready;

    // Outputs are forced to their idle values while reset is held.
    assign run     = reset;
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign any_req = req0_valid | req1_valid;

    // Both valid: the requester not granted last time wins.
    assign sel = (req0_valid & req1_valid) ? ~ptr_q : req1_valid;

    assign cfu_req_valid = run & ~full & any_req;
    assign cfu_req_func  = sel ? req1_func : req0_func;
    assign cfu_req_data  = sel ? req1_data : req0_data;

    assign req0_ready = run & req0_valid & ~sel & ~full & cfu_req_ready;
    assign req1_ready = run & req1_valid &  sel & ~full & cfu_req_ready;

    assign push = cfu_req_valid & cfu_req_ready;

    assign head       = tags_q[rd_ptr_q];
    assign head_valid = run & cfu_resp_valid & ~empty;
    assign head_ready = head ? resp1_ready : resp0_ready;

    assign resp0_valid = head_valid & ~head;
    assign resp1_valid = head_valid &  head;
    assign resp0_data  = cfu_resp_data;
    assign resp1_data  = cfu_resp_data;

    assign cfu_resp_ready = run & (empty | head_ready);

    assign pop    = cfu_resp_valid & cfu_resp_ready & ~empty;
    assign orphan = cfu_resp_valid & cfu_resp_ready &  empty;

    assign err_orphan = err_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tags_d   = tags_q;
        ptr_d    = ptr_q;
        err_d    = err_q | orphan;
        if (push) begin
            tags_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            ptr_d            = sel;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tags_q   <= '0;
            ptr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tags_q   <= tags_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef CFU_ARB_PERF_EN
    logic [15:0] grant0_q, grant0_d;
    logic [15:0] grant1_q, grant1_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        grant0_d = grant0_q;
        grant1_d = grant1_q;
        stall_d  = stall_q;
        if (push & ~sel & (grant0_q != 16'hFFFF)) begin
            grant0_d = grant0_q + 16'd1;
        end
        if (push & sel & (grant1_q != 16'hFFFF)) begin
            grant1_d = grant1_q + 16'd1;
        end
        if (any_req & ~push & (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant0_q <= '0;
            grant1_q <= '0;
            stall_q  <= '0;
        end else begin
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_grant0 = grant0_q;
    assign perf_grant1 = grant1_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_cfu_arbiter2.sv
// Directed bench for cfu_arbiter2: single, contention, full,
// backpressure, orphan and mid-flight reset scenarios.
module tb_cfu_arbiter2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [0:0]  req0_func;
    logic [63:0] req0_data;
    logic [31:0] resp0_data;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [0:0]  req1_func;
    logic [63:0] req1_data;
    logic [31:0] resp1_data;
    logic        cfu_req_valid, cfu_req_ready;
    logic [0:0]  cfu_req_func;
    logic [63:0] cfu_req_data;
    logic        cfu_resp_valid, cfu_resp_ready;
    logic [31:0] cfu_resp_data;
    logic        err_orphan;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    cfu_arbiter2 dut (
        .clock          (clock),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_func      (req0_func),
        .req0_data      (req0_data),
        .resp0_valid    (resp0_valid),
        .resp0_ready    (resp0_ready),
        .resp0_data     (resp0_data),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_func      (req1_func),
        .req1_data      (req1_data),
        .resp1_valid    (resp1_valid),
        .resp1_ready    (resp1_ready),
        .resp1_data     (resp1_data),
        .cfu_req_valid  (cfu_req_valid),
        .cfu_req_ready  (cfu_req_ready),
        .cfu_req_func   (cfu_req_func),
        .cfu_req_data   (cfu_req_data),
        .cfu_resp_valid (cfu_resp_valid),
        .cfu_resp_ready (cfu_resp_ready),
        .cfu_resp_data  (cfu_resp_data),
        .err_orphan     (err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid     = 1'b0;
        req0_func      = '0;
        req0_data      = '0;
        req1_valid     = 1'b0;
        req1_func      = '0;
        req1_data      = '0;
        cfu_req_ready  = 1'b1;
        cfu_resp_valid = 1'b0;
        cfu_resp_data  = '0;
        resp0_ready    = 1'b1;
        resp1_ready    = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        reset = 1'b1;
    endtask

    logic exp;
    logic prev;

    initial begin
        reset = 1'b0;
        idle();
        prev = 1'b0;
        exp  = 1'b0;

        // reset state with provoking inputs
        req0_valid     = 1'b1;
        cfu_resp_valid = 1'b1;
        #2;
        chk("rst_req_valid", cfu_req_valid, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_resp_ready", cfu_resp_ready, 1'b0);
        chk("rst_resp0_valid", resp0_valid, 1'b0);
        chk("rst_err", err_orphan, 1'b0);
        idle();
        tick();
        tick();
        reset = 1'b1;

        // single requester
        req0_valid = 1'b1;
        req0_func  = 1'b1;
        req0_data  = {32'd3, 32'd5};
        #1;
        chk("t1_req_valid", cfu_req_valid, 1'b1);
        chk("t1_rdy0", req0_ready, 1'b1);
        chk("t1_rdy1", req1_ready, 1'b0);
        chk("t1_func", cfu_req_func, 1'b1);
        chk("t1_data", cfu_req_data, {32'd3, 32'd5});
        tick();
        idle();
        #1;
        chk("t1_idle", cfu_req_valid, 1'b0);
        tick();
        cfu_resp_valid = 1'b1;
        cfu_resp_data  = 32'd8;
        #1;
        chk("t1_r0v", resp0_valid, 1'b1);
        chk("t1_r0d", resp0_data, 32'd8);
        chk("t1_r1v", resp1_valid, 1'b0);
        chk("t1_crr", cfu_resp_ready, 1'b1);
        tick();
        cfu_resp_valid = 1'b0;
        resp0_ready    = 1'b0;
        resp1_ready    = 1'b0;
        #1;
        chk("t1_empty", cfu_resp_ready, 1'b1);

        // contention, response latency 1
        do_reset();
        req0_valid = 1'b1;
        req0_func  = 1'b0;
        req0_data  = 64'hA0;
        req1_valid = 1'b1;
        req1_func  = 1'b1;
        req1_data  = 64'hB1;
        for (int k = 0; k < 4; k++) begin
            exp            = ((k % 2) == 0);
            cfu_resp_valid = (k > 0);
            cfu_resp_data  = 32'(100 + k);
            #1;
            chk("t2_gnt1", req1_ready, exp);
            chk("t2_gnt0", req0_ready, !exp);
            chk("t2_func", cfu_req_func, exp);
            chk("t2_data", cfu_req_data, exp ? 64'hB1 : 64'hA0);
            if (k > 0) begin
                chk("t2_r0", resp0_valid, !prev);
                chk("t2_r1", resp1_valid, prev);
                chk("t2_rd", exp ? resp0_data : resp1_data, 32'(100 + k));
            end
            prev = exp;
            tick();
        end
        req0_valid     = 1'b0;
        req1_valid     = 1'b0;
        cfu_resp_valid = 1'b1;
        cfu_resp_data  = 32'd104;
        #1;
        chk("t2_last_r0", resp0_valid, 1'b1);
        chk("t2_last_r1", resp1_valid, 1'b0);
        tick();
        cfu_resp_valid = 1'b0;
        resp0_ready    = 1'b0;
        resp1_ready    = 1'b0;
        #1;
        chk("t2_empty", cfu_resp_ready, 1'b1);

        // full
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 64'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_acc", req0_ready, 1'b1);
            tick();
        end
        #1;
        chk("t3_full_v", cfu_req_valid, 1'b0);
        chk("t3_full_r0", req0_ready, 1'b0);
        chk("t3_full_r1", req1_ready, 1'b0);
        cfu_resp_valid = 1'b1;
        cfu_resp_data  = 32'h77;
        #1;
        chk("t3_pop_v", resp0_valid, 1'b1);
        chk("t3_pop_r", cfu_resp_ready, 1'b1);
        chk("t3_same", req0_ready, 1'b0);
        tick();
        cfu_resp_valid = 1'b0;
        #1;
        chk("t3_next", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;

        // response backpressure, four tag-0 entries queued
        resp0_ready    = 1'b0;
        cfu_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_bp_r", cfu_resp_ready, 1'b0);
            chk("t4_bp_v0", resp0_valid, 1'b1);
            chk("t4_bp_v1", resp1_valid, 1'b0);
            tick();
        end
        resp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_dr_r", cfu_resp_ready, 1'b1);
            chk("t4_dr_v0", resp0_valid, 1'b1);
            tick();
        end
        cfu_resp_valid = 1'b0;
        resp0_ready    = 1'b0;
        #1;
        chk("t4_empty", cfu_resp_ready, 1'b1);
        chk("t4_err", err_orphan, 1'b0);

        // orphan response
        cfu_resp_valid = 1'b1;
        #1;
        chk("t5_rdy", cfu_resp_ready, 1'b1);
        chk("t5_v0", resp0_valid, 1'b0);
        chk("t5_v1", resp1_valid, 1'b0);
        tick();
        cfu_resp_valid = 1'b0;
        #1;
        chk("t5_err", err_orphan, 1'b1);
        tick();
        tick();
        chk("t5_hold", err_orphan, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_clr", err_orphan, 1'b0);
        tick();
        reset = 1'b1;
        idle();

        // reset with three requests in flight
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_acc", req0_ready, 1'b1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        reset      = 1'b0;
        #1;
        chk("t6_rst_v", cfu_req_valid, 1'b0);
        chk("t6_rst_r1", req1_ready, 1'b0);
        chk("t6_rst_crr", cfu_resp_ready, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_r1", req1_ready, 1'b1);
        chk("t6_v", cfu_req_valid, 1'b1);
        chk("t6_empty", cfu_resp_ready, 1'b1);
        tick();
        req1_valid     = 1'b0;
        cfu_resp_valid = 1'b1;
        cfu_resp_data  = 32'h99;
        #1;
        chk("t6_resp1", resp1_valid, 1'b1);
        chk("t6_resp0", resp0_valid, 1'b0);
        tick();
        cfu_resp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
